uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each `rx_data` word on the receiver's one-cycle `rx_ready` strobe and stores it in a circular buffer.
- Presents stored words to the host/bus side through a read-enable interface, with occupancy and overflow status.
- Decouples bursty line reception from a slower or intermittent consumer.

Parameters:
- WORD_LENGTH, 8: data width; matches the receiver's data width.
- DEPTH, 16: number of entries. Must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH): pointer width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  WORD_LENGTH  word from the receiver; sampled only when rx_ready=1.
- rx_ready  input  1  one-cycle strobe from the receiver: push rx_data.
- rd_en  input  1  consumer read request/pop.
- ovf_clr  input  1  clears the sticky overflow flag.
- rd_data  output  WORD_LENGTH  read word.
- rd_valid  output  1  rd_data is valid (meaning depends on mode, see Optional Feature).
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: at least one word was dropped.

Behaviour:
- Reset (synchronous, on clk edge with reset=1):
  - Pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0.
  - Storage contents are don't-care.
  - Reset dominates all other inputs in the same cycle.
  - An in-progress read is abandoned.
- Storage and pointers:
  - Storage is a DEPTH x WORD_LENGTH register array.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
  - count is held in a separate register of ADDR_W+1 bits.
- Push: rx_ready=1 and (!full or a pop in the same cycle) -> mem[wr_ptr]<=rx_data, wr_ptr++.
- Pop: rd_en=1 and !empty -> rd_ptr++.
  - rd_en while empty is ignored: no pointer change, no error.
- count update per cycle: push only +1; pop only -1; both or neither unchanged.
- Simultaneous push and pop:
  - When full: both occur; count stays DEPTH; overflow is not set.
  - When empty: only the push occurs (nothing to pop); count becomes 1.
- Overflow:
  - rx_ready=1, full=1, and no pop in the same cycle -> word dropped; storage and pointers untouched; overflow<=1.
  - overflow stays 1 until ovf_clr=1.
  - If a set and ovf_clr occur in the same cycle, set wins (overflow stays 1).
- empty, full and count are registered and consistent with each other in every cycle.
- Default (registered) read mode:
  - rd_en=1 and !empty at edge N -> rd_data<=mem[rd_ptr] and rd_valid=1 for exactly cycle N+1.
  - rd_valid=0 in any cycle not following an accepted pop.
  - rd_data holds its last value while rd_valid=0.
  - Back-to-back rd_en gives one word per cycle.
- Write-to-read latency (default mode):
  - Word pushed at edge N sets empty=0 after edge N.
  - Earliest accepted rd_en is at edge N+1; data appears in cycle N+2.

Optional Feature:
- Macro: UART_RX_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr] (head word) whenever rd_valid=1.
  - rd_en acts as an acknowledge: it pops the head, and the next word (if any) is shown the following cycle.
  - rd_en while rd_valid=0 is ignored.
  - Word pushed at edge N is visible on rd_data in cycle N+1.
  - Pointer, count, full/empty and overflow rules are unchanged.
- Not defined: the default registered read mode above.

Test Plan:
- Reset, then push 0xA5 and 0x3C on two rx_ready strobes, then rd_en on two consecutive cycles -> rd_data 0xA5 then 0x3C with rd_valid high each cycle; count 2->0; empty=1.
- Push 16 words 0x00..0x0F -> full=1, count=16. Push 0xFF -> overflow=1, count stays 16. Drain all 16 -> reads 0x00..0x0F in order, no 0xFF.
- Full FIFO, rx_ready with 0x77 and rd_en in the same cycle -> count stays 16, overflow stays 0, 0x77 is read last after draining.
- Set overflow, then assert ovf_clr -> overflow=0. Repeat with ovf_clr coinciding with a new drop -> overflow stays 1.
- Wrap-around: push/pop 40 words with interleaved timing (occupancy 0..5) -> output order and values match input; empty and full correct at every cycle.
- Assert reset with 7 words stored and rd_en high -> next cycle count=0, empty=1, rd_valid=0, overflow=0. A subsequent push of 0x12 reads back 0x12. With UART_RX_FIFO_FWFT_EN, rd_valid=1 and rd_data=0x12 one cycle after the push, with no rd_en needed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer behind a UART receiver, with occupancy and sticky overflow.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module uart_rx_fifo #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] rx_data,
    input  logic                   rx_ready,
    input  logic                   rd_en,
    input  logic                   ovf_clr,
    output logic [WORD_LENGTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic [ADDR_W:0]        count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);
    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_W:0]        count_next;
    logic                   push, pop, drop;

    // A pop frees a slot, so a push into a full buffer is still accepted in the same cycle
    always_comb begin
        pop        = rd_en && !empty;
        push       = rx_ready && (!full || pop);
        drop       = rx_ready && full && !pop;
        count_next = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= rx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            empty    <= count_next == '0;
            full     <= count_next == (ADDR_W+1)'(DEPTH);
            overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) rd_data <= mem[rd_ptr];
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based model.
// Works in both read modes (UART_RX_FIFO_FWFT_EN defined or not).
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] rx_data = 0;
    logic       rx_ready = 0;
    logic       rd_en = 0;
    logic       ovf_clr = 0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       empty, full, overflow;

    int errors = 0;
    int checks = 0;
    bit chk = 0;

    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         m_valid = 0;
    logic [7:0] m_data = 0;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered queue; pop happens before push so a full buffer can take a word on a pop
    always @(posedge clk) begin
        automatic bit was_full = q.size() == DEPTH;
        automatic bit p = rd_en && q.size() > 0;
        automatic bit dropped = 0;
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_valid = 0;
            m_data = 0;
        end else begin
            if (p) begin
                m_data = q[0];
                void'(q.pop_front());
            end
            m_valid = p;
            if (rx_ready) begin
                if (!was_full || p) q.push_back(rx_data);
                else dropped = 1;
            end
            m_ovf = dropped ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
        end
    end

    always @(negedge clk) if (chk) begin
        cmp("count", count, q.size());
        cmp("empty", empty, q.size() == 0);
        cmp("full", full, q.size() == DEPTH);
        cmp("overflow", overflow, m_ovf);
`ifdef UART_RX_FIFO_FWFT_EN
        cmp("rd_valid", rd_valid, q.size() > 0);
        if (q.size() > 0) cmp("rd_data", rd_data, q[0]);
`else
        cmp("rd_valid", rd_valid, m_valid);
        cmp("rd_data", rd_data, m_data);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_ready = 1;
        rx_data = d;
        step();
        rx_ready = 0;
    endtask

    // Pops one word and checks it against a literal; leaves rd_en high for back-to-back use
    task automatic pop_check(input logic [7:0] exp);
`ifdef UART_RX_FIFO_FWFT_EN
        rd_en = 0;
        cmp("lit_valid", rd_valid, 1);
        cmp("lit_data", rd_data, exp);
        rd_en = 1;
        step();
`else
        rd_en = 1;
        step();
        cmp("lit_valid", rd_valid, 1);
        cmp("lit_data", rd_data, exp);
`endif
    endtask

    initial begin
        step();
        step();
        reset = 0;
        chk = 1;
        cmp("rst_count", count, 0);
        cmp("rst_empty", empty, 1);
        cmp("rst_valid", rd_valid, 0);
        cmp("rst_data", rd_data, 0);

        push(8'hA5);
        push(8'h3C);
        cmp("two_count", count, 2);
        pop_check(8'hA5);
        pop_check(8'h3C);
        rd_en = 0;
        cmp("two_drained", count, 0);
        cmp("two_empty", empty, 1);

        for (int i = 0; i < 16; i++) push(8'(i));
        cmp("fill_full", full, 1);
        cmp("fill_count", count, 16);
        push(8'hFF);
        cmp("drop_ovf", overflow, 1);
        cmp("drop_count", count, 16);
        for (int i = 0; i < 16; i++) pop_check(8'(i));
        rd_en = 0;
        cmp("drain_empty", empty, 1);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        cmp("ovf_clr", overflow, 0);

        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_ready = 1;
        rx_data = 8'h77;
        rd_en = 1;
        step();
        rx_ready = 0;
        rd_en = 0;
        cmp("both_count", count, 16);
        cmp("both_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) pop_check(8'h20 + 8'(i));
        pop_check(8'h77);
        rd_en = 0;
        cmp("both_empty", empty, 1);

        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        cmp("ovf_set", overflow, 1);
        rx_ready = 1;
        ovf_clr = 1;
        step();
        rx_ready = 0;
        cmp("ovf_set_wins", overflow, 1);
        step();
        ovf_clr = 0;
        cmp("ovf_clr2", overflow, 0);
        rd_en = 1;
        repeat (16) step();
        rd_en = 0;

        begin
            automatic int pushed = 0;
            for (int c = 0; c < 400 && (pushed < 40 || q.size() > 0); c++) begin
                rx_ready = pushed < 40 && q.size() < 5 && $urandom_range(1) == 1;
                rx_data = 8'($urandom);
                rd_en = $urandom_range(2) == 0;
                if (rx_ready) pushed++;
                step();
            end
            rx_ready = 0;
            rd_en = 0;
            cmp("wrap_pushed", pushed, 40);
            cmp("wrap_empty", empty, 1);
        end

        for (int c = 0; c < 600; c++) begin
            rx_ready = $urandom_range(3) < (c < 300 ? 3 : 1);
            rx_data = 8'($urandom);
            rd_en = $urandom_range(3) < (c < 300 ? 1 : 3);
            ovf_clr = $urandom_range(15) == 0;
            step();
        end
        rx_ready = 0;
        ovf_clr = 0;
        rd_en = 0;

        for (int i = 0; i < 7; i++) push(8'h50 + 8'(i));
        rd_en = 1;
        reset = 1;
        step();
        reset = 0;
        rd_en = 0;
        cmp("rst7_count", count, 0);
        cmp("rst7_empty", empty, 1);
        cmp("rst7_valid", rd_valid, 0);
        cmp("rst7_ovf", overflow, 0);
        push(8'h12);
        pop_check(8'h12);
        rd_en = 0;
        step();
        cmp("end_empty", empty, 1);

        chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
